// File: rtl/pipeline_stall_controller.sv
// Single owner of freeze/flush decisions for the 5-stage LC-3b pipeline: stage loads, NOP injection, PC redirect.
// Outputs are combinational from state + inputs; saturating perf counters and a sticky stall watchdog.
module pipeline_stall_controller #(
  parameter int CW      = 16,
  parameter int TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bubble_enable,
  input  logic          imem_req,
  input  logic          imem_resp,
  input  logic          dmem_req,
  input  logic          dmem_resp,
  input  logic          branch_taken,
  input  logic [15:0]   branch_target,
  output logic          load_pc,
  output logic          pc_sel_redirect,
  output logic [15:0]   redirect_pc,
  output logic          load_if_id,
  output logic          load_id_ex,
  output logic          load_ex_mem,
  output logic          load_mem_wb,
  output logic          nop_if_id,
  output logic          nop_id_ex,
  output logic          nop_ex_mem,
  output logic [CW-1:0] dstall_cycles,
  output logic [CW-1:0] istall_cycles,
  output logic [CW-1:0] flush_count,
  output logic          timeout
);

  typedef enum logic {RUN, REDIRECT_WAIT} state_t;

  localparam int RW = $clog2(TIMEOUT + 2);

  state_t          r_state;
  state_t          w_state_next;
  logic [15:0]     r_target_q;
  logic [CW-1:0]   r_dstall_cnt;
  logic [CW-1:0]   r_istall_cnt;
  logic [CW-1:0]   r_flush_cnt;
  logic [RW-1:0]   r_run;
  logic [RW-1:0]   w_run_next;
  logic            r_timeout;
  logic            w_dstall;
  logic            w_istall;
  logic            w_inc_d;
  logic            w_inc_i;
  logic            w_inc_f;
  logic            w_latch_target;

  assign w_dstall = dmem_req & ~dmem_resp;
  assign w_istall = imem_req & ~imem_resp;

  always_comb begin
    w_state_next    = r_state;
    load_pc         = 1'b1;
    pc_sel_redirect = 1'b0;
    redirect_pc     = 16'h0000;
    load_if_id      = 1'b1;
    load_id_ex      = 1'b1;
    load_ex_mem     = 1'b1;
    load_mem_wb     = 1'b1;
    nop_if_id       = 1'b0;
    nop_id_ex       = 1'b0;
    nop_ex_mem      = 1'b0;
    w_inc_d         = 1'b0;
    w_inc_i         = 1'b0;
    w_inc_f         = 1'b0;
    w_latch_target  = 1'b0;

    if (reset) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (w_dstall) begin
      // A D-cache miss freezes everything in either state; any branch must be held upstream.
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      w_inc_d     = 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (branch_taken && !w_istall) begin
            pc_sel_redirect = 1'b1;
            redirect_pc     = branch_target;
            nop_if_id       = 1'b1;
            nop_id_ex       = 1'b1;
            nop_ex_mem      = 1'b1;
            w_inc_f         = 1'b1;
          end else if (branch_taken) begin
            load_pc        = 1'b0;
            nop_if_id      = 1'b1;
            nop_id_ex      = 1'b1;
            nop_ex_mem     = 1'b1;
            w_latch_target = 1'b1;
            w_inc_f        = 1'b1;
            w_inc_i        = 1'b1;
            w_state_next   = REDIRECT_WAIT;
          end else if (w_istall) begin
            load_pc = 1'b0;
            w_inc_i = 1'b1;
            if (bubble_enable) begin
              load_if_id = 1'b0;
              nop_id_ex  = 1'b1;
            end else begin
              nop_if_id = 1'b1;
            end
          end else if (bubble_enable) begin
            load_pc    = 1'b0;
            load_if_id = 1'b0;
            nop_id_ex  = 1'b1;
          end
        end
        REDIRECT_WAIT: begin
          // The fetch in flight is wrong-path, so IF/ID only ever captures a NOP here.
          nop_if_id = 1'b1;
          if (w_istall) begin
            load_pc = 1'b0;
            w_inc_i = 1'b1;
          end else begin
            pc_sel_redirect = 1'b1;
            redirect_pc     = r_target_q;
            w_state_next    = RUN;
          end
        end
        default: w_state_next = RUN;
      endcase
    end
  end

  always_comb begin
    w_run_next = '0;
    if (w_dstall || w_istall) begin
      w_run_next = (r_run == RW'(TIMEOUT)) ? r_run : r_run + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_target_q   <= 16'h0000;
      r_dstall_cnt <= '0;
      r_istall_cnt <= '0;
      r_flush_cnt  <= '0;
      r_run        <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_run   <= w_run_next;
      if (w_latch_target) r_target_q <= branch_target;
      if (w_inc_d && r_dstall_cnt != '1) r_dstall_cnt <= r_dstall_cnt + 1'b1;
      if (w_inc_i && r_istall_cnt != '1) r_istall_cnt <= r_istall_cnt + 1'b1;
      if (w_inc_f && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (TIMEOUT != 0 && w_run_next == RW'(TIMEOUT)) r_timeout <= 1'b1;
    end
  end

  assign dstall_cycles = r_dstall_cnt;
  assign istall_cycles = r_istall_cnt;
  assign flush_count   = r_flush_cnt;
  assign timeout       = r_timeout;

endmodule
